// File: rtl/alu_cmd_sequencer.sv
// ALU issue stage: buffers commands in a FIFO, issues one at a time to a
// combinational ALU through registered operands, and holds each result until consumed.
module alu_cmd_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [DATA_WIDTH-1:0]      cmd_a,
  input  logic [DATA_WIDTH-1:0]      cmd_b,
  input  logic [2:0]                 cmd_op,
  output logic [DATA_WIDTH-1:0]      alu_a,
  output logic [DATA_WIDTH-1:0]      alu_b,
  output logic [2:0]                 alu_op,
  input  logic [DATA_WIDTH-1:0]      alu_result,
  input  logic                       alu_zero,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [DATA_WIDTH-1:0]      res_data,
  output logic                       res_zero,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [7:0]                 done_count
);

  localparam int AW      = $clog2(DEPTH);
  localparam int LW      = AW + 1;
  localparam int ENTRY_W = 2 * DATA_WIDTH + 3;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_e;

  state_e state_q, state_d;

  logic [ENTRY_W-1:0]    mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]            alu_op_q, alu_op_d;
  logic                  res_valid_q, res_valid_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic                  res_zero_q, res_zero_d;
  logic [7:0]            done_count_q, done_count_d;

  logic                  fifo_empty, fifo_full;
  logic                  push, pop, capture, consume;
  logic [ENTRY_W-1:0]    head;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LW'(DEPTH));
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;
  assign head       = mem_q[rd_ptr_q];

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!fifo_empty) state_d = EXEC;
      EXEC:    state_d = HOLD;
      HOLD:    if (res_ready) state_d = fifo_empty ? IDLE : EXEC;
      default: state_d = IDLE;
    endcase
  end

  // FSM: control outputs; pops only from registered occupancy, never bypassing
  always_comb begin
    pop     = 1'b0;
    capture = 1'b0;
    consume = 1'b0;
    unique case (state_q)
      IDLE: pop = !fifo_empty;
      EXEC: capture = 1'b1;
      HOLD: begin
        consume = res_ready;
        pop     = res_ready && !fifo_empty;
      end
      default: ;
    endcase
  end

  // FIFO storage needs no reset: occupancy alone decides validity
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_b, cmd_a};
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    alu_a_d      = pop ? head[DATA_WIDTH-1:0]            : alu_a_q;
    alu_b_d      = pop ? head[2*DATA_WIDTH-1:DATA_WIDTH] : alu_b_q;
    alu_op_d     = pop ? head[ENTRY_W-1:2*DATA_WIDTH]    : alu_op_q;
    res_data_d   = capture ? alu_result : res_data_q;
    res_zero_d   = capture ? alu_zero   : res_zero_q;
    res_valid_d  = res_valid_q;
    if (capture)      res_valid_d = 1'b1;
    else if (consume) res_valid_d = 1'b0;
    done_count_d = consume ? done_count_q + 8'd1 : done_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_zero_q   <= 1'b0;
      done_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_zero_q   <= res_zero_d;
      done_count_q <= done_count_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_zero   = res_zero_q;
  assign fifo_level = level_q;
  assign done_count = done_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with an adder ALU stub (result=a+b, zero=(result==0)).
module tb_alu_cmd_sequencer;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_a, cmd_b;
  logic [2:0]    cmd_op;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic [2:0]    alu_op;
  logic          alu_zero;
  logic          res_valid, res_ready, res_zero;
  logic [DW-1:0] res_data;
  logic [2:0]    fifo_level;
  logic [7:0]    done_count;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  exp_done = 8'd0;

  always #5 clk = ~clk;

  assign alu_result = alu_a + alu_b;
  assign alu_zero   = (alu_result == '0);

  alu_cmd_sequencer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_zero(res_zero),
    .fifo_level(fifo_level), .done_count(done_count)
  );

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [2:0]    op;
    logic [DW-1:0] exp_data;
    logic          exp_zero;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams n commands (a=base+i, b=100) with res_ready high; checks order of results.
  task automatic stream(input int unsigned n, input int unsigned base);
    int unsigned tx = 0;
    int unsigned rx = 0;
    logic        accept;
    res_ready = 1'b1;
    for (int cyc = 0; cyc < 4 * n + 20 && rx < n; cyc++) begin
      cmd_valid = (tx < n);
      cmd_a     = DW'(base + tx);
      cmd_b     = DW'(100);
      cmd_op    = 3'(tx);
      #0;
      accept = cmd_valid && cmd_ready;
      if (res_valid) begin
        chk("stream_data", 64'(res_data), 64'(base + rx + 100));
        rx++;
        exp_done = exp_done + 8'd1;
      end
      tick();
      if (accept) tx++;
    end
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    chk("stream_count", 64'(rx), 64'(n));
  endtask

  initial begin
    int unsigned accepted;
    int          last_cyc;
    int unsigned nres;
    int unsigned vcnt;
    logic [DW-1:0] expq [$];

    vecs[0] = '{a: 32'd5,          b: 32'd7,          op: 3'd3, exp_data: 32'd12,         exp_zero: 1'b0};
    vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'd1,          op: 3'd0, exp_data: 32'd0,          exp_zero: 1'b1};
    vecs[2] = '{a: 32'd0,          b: 32'd0,          op: 3'd7, exp_data: 32'd0,          exp_zero: 1'b1};
    vecs[3] = '{a: 32'h8000_0000,  b: 32'h8000_0000,  op: 3'd5, exp_data: 32'd0,          exp_zero: 1'b1};
    vecs[4] = '{a: 32'h0000_1234,  b: 32'd1,          op: 3'd2, exp_data: 32'h0000_1235,  exp_zero: 1'b0};
    vecs[5] = '{a: 32'hFFFF_FFFE,  b: 32'd1,          op: 3'd6, exp_data: 32'hFFFF_FFFF,  exp_zero: 1'b0};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; res_ready = 1'b0;
    #3;
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_done", 64'(done_count), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_alu_op", 64'(alu_op), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    #9 rst_n = 1'b1;
    tick();

    // Single command latency
    cmd_valid = 1'b1; cmd_a = 32'd5; cmd_b = 32'd7; cmd_op = 3'd3; res_ready = 1'b1;
    tick();                                   // edge N
    cmd_valid = 1'b0;
    chk("lat_level_N", 64'(fifo_level), 64'd1);
    chk("lat_alu_op_N", 64'(alu_op), 64'd0);
    tick();                                   // edge N+1
    chk("lat_alu_op_N1", 64'(alu_op), 64'd3);
    chk("lat_alu_a_N1", 64'(alu_a), 64'd5);
    chk("lat_valid_N1", 64'(res_valid), 64'd0);
    tick();                                   // edge N+2
    chk("lat_valid_N2", 64'(res_valid), 64'd1);
    chk("lat_data", 64'(res_data), 64'd12);
    chk("lat_zero", 64'(res_zero), 64'd0);
    tick();
    exp_done = exp_done + 8'd1;
    chk("lat_done", 64'(done_count), 64'(exp_done));
    chk("lat_valid_drop", 64'(res_valid), 64'd0);
    res_ready = 1'b0;

    // Table-driven single commands
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1; cmd_a = vecs[i].a; cmd_b = vecs[i].b; cmd_op = vecs[i].op;
      tick();
      cmd_valid = 1'b0;
      for (int w = 0; w < 10 && !res_valid; w++) tick();
      chk("vec_valid", 64'(res_valid), 64'd1);
      chk("vec_data", 64'(res_data), 64'(vecs[i].exp_data));
      chk("vec_zero", 64'(res_zero), 64'(vecs[i].exp_zero));
      chk("vec_op", 64'(alu_op), 64'(vecs[i].op));
      tick();
      chk("vec_hold_stable", 64'(res_data), 64'(vecs[i].exp_data));
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      exp_done = exp_done + 8'd1;
      chk("vec_done", 64'(done_count), 64'(exp_done));
    end

    // Backpressure: 8 offers, DEPTH+1 accepted
    accepted = 0;
    for (int i = 0; i < 8; i++) begin
      cmd_valid = 1'b1; cmd_a = DW'(i + 1); cmd_b = DW'(1000); cmd_op = 3'(i);
      #0;
      if (cmd_ready) begin
        accepted++;
        expq.push_back(DW'(i + 1001));
      end
      tick();
    end
    cmd_valid = 1'b0;
    chk("bp_accepted", 64'(accepted), 64'(DEPTH + 1));
    chk("bp_level", 64'(fifo_level), 64'(DEPTH));
    chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
    res_ready = 1'b1;
    last_cyc = -1;
    nres = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (cyc == 1) chk("bp_ready_back", 64'(cmd_ready), 64'd1);
      if (res_valid) begin
        chk("bp_data", 64'(res_data), 64'(expq.size() > 0 ? expq.pop_front() : '0));
        if (last_cyc >= 0) chk("bp_spacing", 64'(cyc - last_cyc), 64'd2);
        last_cyc = cyc;
        nres++;
        exp_done = exp_done + 8'd1;
      end
      tick();
    end
    res_ready = 1'b0;
    chk("bp_results", 64'(nres), 64'(DEPTH + 1));
    chk("bp_done", 64'(done_count), 64'(exp_done));

    // Ordering with pointer wrap
    stream(10, 0);
    chk("wrap_done", 64'(done_count), 64'(exp_done));

    // done_count wrap: bring it to exactly 0, then one more
    stream(256 - int'(exp_done), 500);
    chk("done_wrap0", 64'(done_count), 64'd0);
    stream(1, 7);
    chk("done_wrap1", 64'(done_count), 64'd1);

    // Reset mid-operation: one in HOLD, three queued
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_a = DW'(i + 40); cmd_b = DW'(2); cmd_op = 3'd1;
      tick();
    end
    cmd_valid = 1'b0;
    chk("mr_level_pre", 64'(fifo_level), 64'd3);
    chk("mr_valid_pre", 64'(res_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", 64'(res_valid), 64'd0);
    chk("mr_level", 64'(fifo_level), 64'd0);
    chk("mr_done", 64'(done_count), 64'd0);
    chk("mr_cmd_ready", 64'(cmd_ready), 64'd1);
    #2 rst_n = 1'b1;
    res_ready = 1'b1;
    vcnt = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      tick();
      if (res_valid) vcnt++;
    end
    chk("mr_no_stale", 64'(vcnt), 64'd0);
    chk("mr_done_after", 64'(done_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Upstream issue stage for the ALU. It accepts ALU commands (a, b, op) over a valid/ready interface and buffers them in a small FIFO. It drives one command at a time into the combinational alu through registered operand outputs, then captures alu result/zero into a result register with a valid/ready output. It also keeps a wrapping 8-bit count of completed results.

Parameters:
DATA_WIDTH, 32, operand/result width (matches word_t)
DEPTH, 4, command FIFO entries; power of 2, >=2

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  FIFO can accept (= !full)
cmd_a  input  DATA_WIDTH  operand a
cmd_b  input  DATA_WIDTH  operand b
cmd_op  input  3  ALU opcode, passed through unmodified
alu_a  output  DATA_WIDTH  registered operand to alu .a
alu_b  output  DATA_WIDTH  registered operand to alu .b
alu_op  output  3  registered opcode to alu .op
alu_result  input  DATA_WIDTH  from alu .result
alu_zero  input  1  from alu .zero
res_valid  output  1  result register holds an unconsumed result
res_ready  input  1  consumer accepts result
res_data  output  DATA_WIDTH  captured alu_result
res_zero  output  1  captured alu_zero
fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy
done_count  output  8  results consumed, wraps 255->0

Behaviour:
- Single clock domain. Reset is asynchronous, active-low; clk and rst_n as named above.
- Reset values: FIFO empty, state IDLE, alu_a/alu_b/alu_op=0, res_valid=0, res_data=0, res_zero=0, fifo_level=0, done_count=0. cmd_ready=1 because it is combinational from an empty FIFO.
- Push: the FIFO writes on any edge where cmd_valid && cmd_ready. cmd_ready depends only on registered occupancy; it ignores a same-cycle pop, so a full FIFO never accepts a command.
- Pop: done only by the FSM and based on registered occupancy. There is no bypass: a command pushed into an empty FIFO is popped no earlier than the next cycle.
- Simultaneous push and pop: fifo_level is unchanged; the pointers wrap modulo DEPTH.
- FSM states: IDLE, EXEC, HOLD.
  - IDLE: if the FIFO is non-empty, pop the head into alu_a/alu_b/alu_op and go to EXEC. Otherwise stay; operand registers hold their last values.
  - EXEC: one cycle for the ALU to settle. At the closing edge, res_data<=alu_result, res_zero<=alu_zero, res_valid<=1; go to HOLD.
  - HOLD: res_valid=1; res_data and res_zero are stable until the handshake. On res_valid && res_ready:
    - done_count increments, 8-bit wrap.
    - If the FIFO is non-empty, pop the next command into the operand registers in the same edge, res_valid<=0, go to EXEC.
    - Otherwise res_valid<=0, go to IDLE.
  - HOLD without res_ready: stay; no pop occurs.
- Latency: a command accepted at edge N appears on alu_* after edge N+1. res_valid is high after edge N+2.
- Sustained throughput: 1 result per 2 cycles with res_ready tied high.
- Capacity under backpressure: DEPTH commands in the FIFO plus 1 in EXEC/HOLD.
- alu_op is never decoded; any 3-bit value passes through.
- Reset asserted mid-operation:
  - All state returns to reset values immediately, without waiting for a clock.
  - Queued commands and any pending result are discarded.
  - res_valid drops asynchronously.
- Opcode and operand values must not change while in EXEC or HOLD.

Test Plan:
Bench ALU stub: result=a+b, zero=(result==0).
- Single command: a=5, b=7, op=3, res_ready=1 -> alu_op=3 after edge N+1; res_valid high after edge N+2 with res_data=12, res_zero=0; done_count=1.
- Zero flag: a=32'hFFFF_FFFF, b=1 -> res_data=0, res_zero=1.
- Backpressure: res_ready=0, offer 8 commands back-to-back:
  - exactly 5 are accepted (DEPTH+1); cmd_ready=0 with fifo_level=4.
  - then set res_ready=1 -> 5 results in order, one every 2 cycles; cmd_ready returns to 1 after the first pop.
- Ordering/wrap: stream 10 commands with a=i, b=100 through DEPTH=4 -> res_data=100..109 in order; fifo pointers wrap without loss.
- done_count wrap: complete 256 results -> done_count returns to 0; the 257th result gives 1.
- Reset mid-operation: 3 commands queued, one in HOLD, assert rst_n=0 between edges:
  - res_valid=0, fifo_level=0, done_count=0 immediately.
  - after release, no stale result is ever produced.
